// File: rtl/ks_add_scheduler.sv
// Round-robin scheduler sharing one external combinational Kogge-Stone adder
// between NREQ valid/ready requesters; results land in a single ID-tagged slot.
module ks_add_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = 2
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_cin,
    input  logic [WIDTH-1:0]      add_sum,
    input  logic                  add_cout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic [15:0]           op_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [15:0]      op_count_q, op_count_d;

    logic             slot_free;
    logic             found;
    logic             grant;
    logic [IDW-1:0]   grant_idx;
    logic [IDW:0]     idx_w;

    // Rotating priority search: first valid requester at or above ptr wins.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so
        // no path through the block leaves it unassigned (no latch).
        found     = 1'b0;
        grant_idx = '0;
        idx_w     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_w = {1'b0, ptr_q} + (IDW+1)'(k);
            if (idx_w >= (IDW+1)'(NREQ)) begin
                idx_w = idx_w - (IDW+1)'(NREQ);
            end
            if (!found && req_valid[idx_w[IDW-1:0]]) begin
                found     = 1'b1;
                grant_idx = idx_w[IDW-1:0];
            end
        end
    end

    assign slot_free = (state_q == EMPTY) || rsp_ready;
    assign grant     = found && slot_free && !wb_rst_i;

    // Adder inputs are held at zero without a grant to keep the adder quiet.
    always_comb begin
        req_ready = '0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        if (grant) begin
            req_ready = NREQ'(1) << grant_idx;
            add_a     = req_a[grant_idx*WIDTH +: WIDTH];
            add_b     = req_b[grant_idx*WIDTH +: WIDTH];
            add_cin   = req_cin[grant_idx];
        end
    end

    always_comb begin
        state_d    = state_q;
        rsp_id_d   = rsp_id_q;
        rsp_sum_d  = rsp_sum_q;
        rsp_cout_d = rsp_cout_q;
        ptr_d      = ptr_q;
        op_count_d = op_count_q;
        case (state_q)
            EMPTY: if (grant) state_d = FULL;
            FULL:  if (rsp_ready && !grant) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (grant) begin
            rsp_id_d   = grant_idx;
            rsp_sum_d  = add_sum;
            rsp_cout_d = add_cout;
            ptr_d      = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (wb_rst_i) begin
            state_q    <= EMPTY;
            rsp_id_q   <= '0;
            rsp_sum_q  <= '0;
            rsp_cout_q <= 1'b0;
            ptr_q      <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            rsp_id_q   <= rsp_id_d;
            rsp_sum_q  <= rsp_sum_d;
            rsp_cout_q <= rsp_cout_d;
            ptr_q      <= ptr_d;
            op_count_q <= op_count_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign op_count  = op_count_q;

endmodule

// File: doc/ks_add_scheduler.md
# ks_add_scheduler

Round-robin scheduler that shares one combinational Kogge-Stone adder (prefix network plus sum stage) between `NREQ` requesters. Each requester presents operands with a valid/ready handshake. The scheduler grants one requester per cycle and drives the shared adder. It captures sum and carry-out in a single-entry response register tagged with the requester ID, and holds that entry until the consumer accepts it. It sits between the user-project bus/logic clients and the adder instance in the user project area.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `WIDTH`, 16, operand width; must match the adder instance
- `IDW`, 2, requester ID width, equal to clog2(`NREQ`)

Ports:
- `wb_clk_i`  input  1  sole clock; all state updates on the rising edge
- `wb_rst_i`  input  1  synchronous, active-high reset
- `req_valid`  input  NREQ  bit i: requester i has an operation pending
- `req_ready`  output  NREQ  one-hot-or-zero grant; bit i high means requester i is accepted this cycle
- `req_a`  input  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- `req_b`  input  NREQ*WIDTH  operand B, same packing
- `req_cin`  input  NREQ  carry-in per requester
- `add_a`, `add_b`  output  WIDTH  operands driven to the shared adder
- `add_cin`  output  1  carry-in to the shared adder
- `add_sum`  input  WIDTH  adder sum, combinational from `add_*`
- `add_cout`  input  1  adder carry-out
- `rsp_valid`  output  1  response register holds a result
- `rsp_ready`  input  1  consumer accepts the response
- `rsp_id`  output  IDW  requester index that produced the result
- `rsp_sum`  output  WIDTH  registered sum
- `rsp_cout`  output  1  registered carry-out
- `op_count`  output  16  number of accepted operations, wraps at 2^16

## Operation
- Output slot is free when `rsp_valid`=0 or (`rsp_valid`=1 and `rsp_ready`=1), i.e. it is drained this cycle.
- Arbitration is combinational each cycle, only while the slot is free.
  - Search `req_valid` starting at index `ptr` and going upward modulo `NREQ`.
  - The first set bit i wins; `req_ready[i]`=1 and all other bits are 0.
- Slot not free: `req_ready` = 0.
- Adder drive:
  - With a grant to i: `add_a`=`req_a[i]`, `add_b`=`req_b[i]`, `add_cin`=`req_cin[i]`.
  - Without a grant: all three are 0, which keeps the adder quiet.
- On an edge with a grant to i:
  - `rsp_sum` ← `add_sum`, `rsp_cout` ← `add_cout`, `rsp_id` ← i, `rsp_valid` ← 1.
  - `ptr` ← (i+1) mod `NREQ`.
  - `op_count` ← `op_count`+1, modulo 2^16.
- On an edge with `rsp_valid`=1, `rsp_ready`=1 and no grant: `rsp_valid` ← 0; `rsp_id`/`rsp_sum`/`rsp_cout` hold their last value.
- Drain and grant in the same cycle: the new result overwrites the slot and `rsp_valid` stays 1. This is back-to-back, full throughput.
- `ptr` does not change on cycles without a grant.
- A requester must hold `req_valid` and its operands stable until it sees `req_ready`. The scheduler never drops an asserted request.
- State machine, derived from `rsp_valid`:
  - EMPTY (0): moves to FULL on a grant.
  - FULL (1): stays FULL on (drain and grant) or on no drain; moves to EMPTY on (drain, no grant).

## Timing
- Reset, while `wb_rst_i`=1 at an edge:
  - `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_cout`=0, `ptr`=0, `op_count`=0.
  - `req_ready` is forced to 0 during reset cycles. Reset wins over a simultaneous grant or drain.
- Latency: a request accepted at edge T has its result on `rsp_*` with `rsp_valid`=1 after T, visible in cycle T+1.
- Throughput: one operation per cycle while `rsp_ready`=1.
- Backpressure: `rsp_ready`=0 with the slot FULL stalls all requesters. The response outputs hold stable until accepted.
- Fairness: under continuous requests from all requesters, the grant order is 0,1,…,NREQ-1,0,… Any requester waits at most `NREQ`-1 grants.
- Width rule: `rsp_sum` is `add_sum` unmodified, i.e. (A+B+cin) mod 2^WIDTH; `rsp_cout` is bit WIDTH of the full sum.
- Reset mid-operation: a pending response is discarded with no handshake. `op_count` restarts from 0.
- No combinational path from `rsp_ready` to `rsp_*`. Paths from `rsp_ready`/`req_valid` to `req_ready`/`add_*` are allowed.

## Test plan
- Reset, then a single requester: req 2 presents A=0x1234, B=0x0FF0, cin=1 → `req_ready`=4'b0100 in the same cycle. Next cycle: `rsp_valid`=1, `rsp_id`=2, `rsp_sum`=0x2225, `rsp_cout`=0, `op_count`=1.
- Carry/wrap: A=0xFFFF, B=0x0001, cin=0 → `rsp_sum`=0x0000, `rsp_cout`=1. Then A=0xFFFF, B=0xFFFF, cin=1 → `rsp_sum`=0xFFFF, `rsp_cout`=1.
- Round-robin: all four requesters valid with `rsp_ready` held at 1 for 8 cycles → `rsp_id` sequence 0,1,2,3,0,1,2,3 with `rsp_valid` continuously 1; `op_count`=8.
- Backpressure: slot FULL with `rsp_ready`=0 for 5 cycles while req 1 and req 3 are valid → `req_ready`=0 and `rsp_*` unchanged throughout. After `rsp_ready`=1 for one cycle, exactly one new grant follows, to the next requester at or after `ptr`, in the same cycle as the drain.
- Drain without new request: slot FULL, `rsp_ready`=1, no `req_valid` → `rsp_valid` drops to 0 next cycle and `add_a`/`add_b`/`add_cin`=0.
- Reset mid-stream: assert `wb_rst_i` during continuous traffic with `rsp_valid`=1 → next cycle `rsp_valid`=0, `op_count`=0, `ptr`=0. After release, the first grant goes to the lowest valid index.
